// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the ALU dispatch front end.
// Holds data/register widths, ALU opcode encodings, instruction field
// offsets, the decoded-instruction struct and a raw-to-struct decoder.
package alu_dispatch_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned IW   = 4 + 2*RW + DW;

  // ALU opcode encodings shared with the ALU
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] NOT = 3'd5;
  localparam logic [2:0] SL  = 3'd6;
  localparam logic [2:0] SR  = 3'd7;

  // Instruction field offsets, MSB first: opcode, rd, rs, imm_sel, imm
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned SEL_BIT = DW;
  localparam int unsigned RS_LSB  = DW + 1;
  localparam int unsigned RD_LSB  = DW + 1 + RW;
  localparam int unsigned OPC_LSB = DW + 1 + 2*RW;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic          imm_sel;
    logic [DW-1:0] imm;      // imm[RW-1:0] doubles as rt when imm_sel=0
  } instr_t;

  function automatic instr_t decode_instr(input logic [IW-1:0] raw);
    instr_t d;
    d.opcode  = raw[OPC_LSB +: 3];
    d.rd      = raw[RD_LSB +: RW];
    d.rs      = raw[RS_LSB +: RW];
    d.imm_sel = raw[SEL_BIT];
    d.imm     = raw[IMM_LSB +: DW];
    return d;
  endfunction

endpackage

// File: rtl/alu_dispatch_rf.sv
// NREG x DW register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port, async clear.
// Ports: clk, rst_n; ra_addr/ra_data, rb_addr/rb_data (operand reads);
// dbg_addr/dbg_data (debug read); we/wa/wd (write).
module alu_dispatch_rf
  import alu_dispatch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Next-state: single write port
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback front end for the 8-bit combinational ALU.
// Pipeline D (decode/RF read) -> X (drive ALU) -> W (write back, report).
// Ports: in_valid/in_ready/in_instr (issue handshake); alu_opcode/alu_a/
// alu_b to the ALU, alu_result/alu_zero back; out_valid/out_rd/out_data/
// out_zero completion report; busy; dbg_sel/dbg_data RF debug read.
// Build option ALU_DISPATCH_BYPASS_EN: forward alu_result into D on a
// distance-1 RAW hazard instead of stalling D for one cycle.
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  output logic [2:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          out_valid,
  output logic [RW-1:0] out_rd,
  output logic [DW-1:0] out_data,
  output logic          out_zero,
  output logic          busy,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic          d_valid_q, d_valid_d;
  instr_t        d_instr_q, d_instr_d;
  logic          x_valid_q, x_valid_d;
  logic [2:0]    x_opc_q, x_opc_d;
  logic [RW-1:0] x_rd_q, x_rd_d;
  logic [DW-1:0] x_a_q, x_a_d;
  logic [DW-1:0] x_b_q, x_b_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_zero_q, out_zero_d;

  logic [RW-1:0] rt;
  logic [DW-1:0] rf_a, rf_b, op_a, op_b;
  logic          hazard_a, hazard_b, stall, advance, accept;

  assign rt = d_instr_q.imm[RW-1:0];

  // X result is written at the same edge it leaves X, so only distance-1
  // dependencies need attention.
  alu_dispatch_rf u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (d_instr_q.rs),
    .ra_data  (rf_a),
    .rb_addr  (rt),
    .rb_data  (rf_b),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data),
    .we       (x_valid_q),
    .wa       (x_rd_q),
    .wd       (alu_result)
  );

  // Hazard detection and D operand selection
  always_comb begin
    hazard_a = d_valid_q && x_valid_q && (d_instr_q.rs == x_rd_q);
    hazard_b = d_valid_q && x_valid_q && !d_instr_q.imm_sel && (rt == x_rd_q);
    op_a     = rf_a;
    op_b     = d_instr_q.imm_sel ? d_instr_q.imm : rf_b;
`ifdef ALU_DISPATCH_BYPASS_EN
    if (hazard_a) op_a = alu_result;
    if (hazard_b) op_b = alu_result;
    stall = 1'b0;
`else
    stall = hazard_a || hazard_b;
`endif
  end

  // Pipeline advance and next-state
  always_comb begin
    advance     = d_valid_q && !stall;
    in_ready    = !d_valid_q || !stall;
    accept      = in_valid && in_ready;

    d_valid_d   = accept || (d_valid_q && stall);
    d_instr_d   = d_instr_q;
    x_valid_d   = advance;
    x_opc_d     = x_opc_q;
    x_rd_d      = x_rd_q;
    x_a_d       = x_a_q;
    x_b_d       = x_b_q;
    out_valid_d = x_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;

    if (accept) d_instr_d = decode_instr(in_instr);
    // X registers hold when no instruction enters, keeping ALU inputs stable
    if (advance) begin
      x_opc_d = d_instr_q.opcode;
      x_rd_d  = d_instr_q.rd;
      x_a_d   = op_a;
      x_b_d   = op_b;
    end
    if (x_valid_q) begin
      out_rd_d   = x_rd_q;
      out_data_d = alu_result;
      out_zero_d = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q   <= 1'b0;
      d_instr_q   <= '0;
      x_valid_q   <= 1'b0;
      x_opc_q     <= '0;
      x_rd_q      <= '0;
      x_a_q       <= '0;
      x_b_q       <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      d_valid_q   <= d_valid_d;
      d_instr_q   <= d_instr_d;
      x_valid_q   <= x_valid_d;
      x_opc_q     <= x_opc_d;
      x_rd_q      <= x_rd_d;
      x_a_q       <= x_a_d;
      x_b_q       <= x_b_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign alu_opcode = x_opc_q;
  assign alu_a      = x_a_q;
  assign alu_b      = x_b_q;
  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign out_data   = out_data_q;
  assign out_zero   = out_zero_q;
  assign busy       = d_valid_q || x_valid_q || out_valid_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch with a behavioural ALU attached.
// Honors ALU_DISPATCH_BYPASS_EN for the hazard-timing expectations.
`timescale 1ns/1ps
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_instr = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_zero;
  logic          out_valid;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_data;
  logic          out_zero;
  logic          busy;
  logic [RW-1:0] dbg_sel = '0;
  logic [DW-1:0] dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_rd     (out_rd),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .busy       (busy),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU; shifts are by one bit
  always_comb begin
    case (alu_opcode)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      AND:     alu_result = alu_a & alu_b;
      OR:      alu_result = alu_a | alu_b;
      XOR:     alu_result = alu_a ^ alu_b;
      NOT:     alu_result = ~alu_a;
      SL:      alu_result = alu_a << 1;
      default: alu_result = alu_a >> 1;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion scoreboard
  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          zero;
  } res_t;
  res_t exp_q[$];

  int cyc = 0;
  int last_out_cyc = -10;
  int run_len = 0;
  int max_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid) begin
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid with rd=%0d data=0x%0h, expected no completion",
                 out_rd, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_rd", 32'(out_rd), 32'(e.rd));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_zero", 32'(out_zero), 32'(e.zero));
      end
    end else begin
      run_len = 0;
    end
  end

  // Offer one instruction; returns at the negedge after it is accepted
  task automatic send(input logic [2:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                      input logic sel, input logic [DW-1:0] imm, input logic track,
                      input logic [DW-1:0] exp_data, input logic exp_zero);
    int n = 0;
    in_instr = {op, rd, rs, sel, imm};
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      in_valid = 1'b0;
    end else begin
      if (track) exp_q.push_back('{rd, exp_data, exp_zero});
      @(negedge clk);
    end
  endtask

  // Wait for the pipeline to empty; busy must fall the cycle after the last completion
  task automatic drain(input string name);
    int n = 0;
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy && n < 60);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: busy=1 after %0d cycles, expected 0", name, n);
    end else begin
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy_drop"}, 32'(cyc), 32'(last_out_cyc + 1));
    end
  endtask

  task automatic check_rf(input string name, input logic [RW-1:0] idx, input logic [DW-1:0] exp);
    dbg_sel = idx;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic          sel;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic          exp_zero;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic [RW-1:0] srd;
    logic [DW-1:0] simm;
    int gap;

    tbl[0]  = '{ADD, 2'd3, 2'd0, 1'b1, 8'h80, 8'h80, 1'b0};
    tbl[1]  = '{SL,  2'd3, 2'd3, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[2]  = '{ADD, 2'd2, 2'd0, 1'b1, 8'h01, 8'h01, 1'b0};
    tbl[3]  = '{SR,  2'd2, 2'd2, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{ADD, 2'd3, 2'd0, 1'b1, 8'hFF, 8'hFF, 1'b0};
    tbl[5]  = '{ADD, 2'd3, 2'd3, 1'b1, 8'h01, 8'h00, 1'b1};
    tbl[6]  = '{ADD, 2'd2, 2'd0, 1'b1, 8'h3C, 8'h3C, 1'b0};
    tbl[7]  = '{AND, 2'd1, 2'd2, 1'b1, 8'h0F, 8'h0C, 1'b0};
    tbl[8]  = '{OR,  2'd1, 2'd1, 1'b1, 8'h30, 8'h3C, 1'b0};
    tbl[9]  = '{XOR, 2'd3, 2'd1, 1'b0, 8'h02, 8'h00, 1'b1};
    tbl[10] = '{NOT, 2'd3, 2'd2, 1'b1, 8'h00, 8'hC3, 1'b0};
    tbl[11] = '{SUB, 2'd1, 2'd3, 1'b1, 8'h03, 8'hC0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    for (int r = 0; r < int'(NREG); r++) check_rf("rst_rf", RW'(r), 8'h00);

    // First instruction latency
    send(ADD, 2'd1, 2'd0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0);
    in_valid = 1'b0;
    check("lat_e0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_e2", 32'(out_valid), 32'd1);
    drain("first");
    check_rf("first_rf", 2'd1, 8'h05);

    // Table of isolated operations
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].sel, tbl[i].imm, 1'b1,
           tbl[i].exp_data, tbl[i].exp_zero);
      drain("tbl");
      check_rf("tbl_rf", tbl[i].rd, tbl[i].exp_data);
    end
    check("alu_hold_opcode", 32'(alu_opcode), 32'(SUB));
    check("alu_hold_a", 32'(alu_a), 32'h0C3);
    check("alu_hold_b", 32'(alu_b), 32'h003);

    // Distance-1 RAW: r1=5 then r2=r1-r1
    send(ADD, 2'd1, 2'd0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0);
    send(SUB, 2'd2, 2'd1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b1);
    in_valid = 1'b0;
`ifdef ALU_DISPATCH_BYPASS_EN
    check("haz_ready", 32'(in_ready), 32'd1);
`else
    check("haz_ready", 32'(in_ready), 32'd0);
`endif
    @(negedge clk);
    check("haz_ready_after", 32'(in_ready), 32'd1);
    check("haz_first_out", 32'(out_valid), 32'd1);
    @(negedge clk);
`ifdef ALU_DISPATCH_BYPASS_EN
    check("haz_sub_out", 32'(out_valid), 32'd1);
`else
    check("haz_sub_out_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("haz_sub_out", 32'(out_valid), 32'd1);
`endif
    drain("haz");
    check_rf("haz_rf", 2'd2, 8'h00);

    // Full-throughput stream of independent immediates
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      srd  = RW'(1 + i % 3);
      simm = DW'(8'h10 + i);
      check("stream_ready", 32'(in_ready), 32'd1);
      send(ADD, srd, 2'd0, 1'b1, simm, 1'b1, simm, 1'b0);
    end
    drain("stream");
    check("stream_run", 32'(max_run), 32'd8);
    check_rf("stream_r1", 2'd1, 8'h16);
    check_rf("stream_r2", 2'd2, 8'h17);
    check_rf("stream_r3", 2'd3, 8'h15);

    // Reset with two instructions in flight
    send(ADD, 2'd1, 2'd0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    send(ADD, 2'd2, 2'd0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    in_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < int'(NREG); r++) check_rf("mid_rst_rf", RW'(r), 8'h00);
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_no_out", 32'(out_valid), 32'd0);
    end

    // Dependent chain r1 += 1 with random issue gaps
    for (int i = 0; i < 10; i++) begin
      send(ADD, 2'd1, 2'd1, 1'b1, 8'h01, 1'b1, DW'(i + 1), 1'b0);
      in_valid = 1'b0;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end
    drain("chain");
    check_rf("chain_r1", 2'd1, 8'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
